// File: rtl/ucsbece154a_alu_bist.sv
// ucsbece154a_alu_bist -- built-in self-test initiator for the 32-bit
// single-cycle ALU (ADD/SUB/AND/OR/SLT plus zero/overflow/carry/negative).
//
// A start pulse in IDLE or DONE launches a run of NUM_VECTORS vectors. The
// bench registers each vector on alu_a/alu_b/alu_f. It compares the ALU's
// combinational response with an internal golden model on the next edge.
// It then reports pass, err_count and first_fail_idx once done is high.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle run request (ignored while running)
//   busy, done, pass      run status; pass valid while done=1
//   err_count             mismatching vectors, saturating at 16'hFFFF
//   first_fail_idx        first mismatching index, 16'hFFFF if none
//   alu_a, alu_b, alu_f   vector driven into the ALU
//   alu_result, alu_zero, alu_overflow, alu_carry, alu_negative  ALU response
//
// Optional build macro: ALU_BIST_STOP_ON_FAIL_EN. When defined, the first
// mismatch ends the run immediately and the failing vector is held on
// alu_a/b/f. When undefined, every vector is applied.
module ucsbece154a_alu_bist #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hACE1_2025
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_fail_idx,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_f,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry,
    input  logic        alu_negative
);

    // ALU op encodings, matching ALUcontrol_* in ucsbece154a_defines.svh
    localparam logic [2:0] ALU_CTRL_ADD = 3'b000;
    localparam logic [2:0] ALU_CTRL_SUB = 3'b001;
    localparam logic [2:0] ALU_CTRL_AND = 3'b010;
    localparam logic [2:0] ALU_CTRL_OR  = 3'b011;
    localparam logic [2:0] ALU_CTRL_SLT = 3'b101;
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    // Right-shifting Galois LFSR step
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        if (s[0]) begin
            lfsr_step = (s >> 1) ^ LFSR_TAPS;
        end else begin
            lfsr_step = s >> 1;
        end
    endfunction

    // Op selected by the 0..4 cycle counter
    function automatic logic [2:0] op_of(input logic [2:0] cnt);
        case (cnt)
            3'd0:    op_of = ALU_CTRL_ADD;
            3'd1:    op_of = ALU_CTRL_SUB;
            3'd2:    op_of = ALU_CTRL_AND;
            3'd3:    op_of = ALU_CTRL_OR;
            3'd4:    op_of = ALU_CTRL_SLT;
            default: op_of = ALU_CTRL_ADD;
        endcase
    endfunction

    // Golden response packed as {result, zero, overflow, carry, negative}
    function automatic logic [35:0] golden_resp(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic [2:0]  f);
        logic [32:0] sum_s;
        logic [32:0] dif_s;
        logic [31:0] res_s;
        logic        ovf_s;
        logic        cry_s;
        sum_s = {1'b0, a} + {1'b0, b};
        // carry-out of a + ~b + 1, i.e. "no borrow"
        dif_s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        case (f)
            ALU_CTRL_ADD: begin
                res_s = sum_s[31:0];
                cry_s = sum_s[32];
                ovf_s = (a[31] == b[31]) && (res_s[31] != a[31]);
            end
            ALU_CTRL_SUB: begin
                res_s = dif_s[31:0];
                cry_s = dif_s[32];
                ovf_s = (a[31] != b[31]) && (res_s[31] != a[31]);
            end
            ALU_CTRL_AND: begin
                res_s = a & b;
                cry_s = 1'b0;
                ovf_s = 1'b0;
            end
            ALU_CTRL_OR: begin
                res_s = a | b;
                cry_s = 1'b0;
                ovf_s = 1'b0;
            end
            ALU_CTRL_SLT: begin
                res_s = {31'd0, ($signed(a) < $signed(b))};
                cry_s = 1'b0;
                ovf_s = 1'b0;
            end
            default: begin
                res_s = 32'd0;
                cry_s = 1'b0;
                ovf_s = 1'b0;
            end
        endcase
        golden_resp = {res_s, (res_s == 32'd0), ovf_s, cry_s, res_s[31]};
    endfunction

    state_t      state_q, state_d;
    logic [15:0] vec_idx_q, vec_idx_d;
    logic [2:0]  op_cnt_q, op_cnt_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_f_q, alu_f_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [15:0] err_count_q, err_count_d;
    logic [15:0] first_fail_idx_q, first_fail_idx_d;

    logic [15:0] load_idx_s;
    logic [2:0]  load_op_cnt_s;
    logic [31:0] load_lfsr_s;
    logic [31:0] vec_a_s;
    logic [31:0] vec_b_s;
    logic [31:0] lfsr_after_s;
    logic        mismatch_s;
    logic [15:0] err_next_s;
    logic [15:0] ffi_next_s;

    // Candidate vector to load next: vector 0 on start, vec_idx+1 in RUN
    always_comb begin
        if (state_q == RUN) begin
            load_idx_s    = vec_idx_q + 16'd1;
            load_op_cnt_s = (op_cnt_q == 3'd4) ? 3'd0 : op_cnt_q + 3'd1;
            load_lfsr_s   = lfsr_q;
        end else begin
            load_idx_s    = 16'd0;
            load_op_cnt_s = 3'd0;
            load_lfsr_s   = SEED;
        end
        // The LFSR only steps when a pseudo-random vector is consumed
        if (load_idx_s < 16'd5) begin
            vec_a_s      = 32'h7FFF_FFFF;
            vec_b_s      = 32'h0000_0001;
            lfsr_after_s = load_lfsr_s;
        end else if (load_idx_s < 16'd10) begin
            vec_a_s      = 32'h8000_0000;
            vec_b_s      = 32'h0000_0001;
            lfsr_after_s = load_lfsr_s;
        end else begin
            vec_a_s      = load_lfsr_s;
            vec_b_s      = {load_lfsr_s[15:0], load_lfsr_s[31:16]} ^ 32'h5555_5555;
            lfsr_after_s = lfsr_step(load_lfsr_s);
        end
    end

    // Compare the ALU response for the registered vector; fold into counters
    always_comb begin
        mismatch_s = ({alu_result, alu_zero, alu_overflow, alu_carry, alu_negative}
                      != golden_resp(alu_a_q, alu_b_q, alu_f_q));
        if (mismatch_s && (err_count_q != 16'hFFFF)) begin
            err_next_s = err_count_q + 16'd1;
        end else begin
            err_next_s = err_count_q;
        end
        if (mismatch_s && (first_fail_idx_q == 16'hFFFF)) begin
            ffi_next_s = vec_idx_q;
        end else begin
            ffi_next_s = first_fail_idx_q;
        end
    end

    // FSM next-state and registered-output computation
    always_comb begin
        state_d          = state_q;
        vec_idx_d        = vec_idx_q;
        op_cnt_d         = op_cnt_q;
        lfsr_d           = lfsr_q;
        alu_a_d          = alu_a_q;
        alu_b_d          = alu_b_q;
        alu_f_d          = alu_f_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        err_count_d      = err_count_q;
        first_fail_idx_d = first_fail_idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d          = RUN;
                    vec_idx_d        = 16'd0;
                    op_cnt_d         = 3'd0;
                    lfsr_d           = lfsr_after_s;
                    alu_a_d          = vec_a_s;
                    alu_b_d          = vec_b_s;
                    alu_f_d          = op_of(3'd0);
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    err_count_d      = 16'd0;
                    first_fail_idx_d = 16'hFFFF;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                err_count_d      = err_next_s;
                first_fail_idx_d = ffi_next_s;
`ifdef ALU_BIST_STOP_ON_FAIL_EN
                if (mismatch_s) begin
                    // failing vector stays on alu_a/b/f for debug
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else if (vec_idx_q == LAST_IDX) begin
`else
                if (vec_idx_q == LAST_IDX) begin
`endif
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_next_s == 16'd0);
                end else begin
                    vec_idx_d = load_idx_s;
                    op_cnt_d  = load_op_cnt_s;
                    lfsr_d    = lfsr_after_s;
                    alu_a_d   = vec_a_s;
                    alu_b_d   = vec_b_s;
                    alu_f_d   = op_of(load_op_cnt_s);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            vec_idx_q        <= 16'd0;
            op_cnt_q         <= 3'd0;
            lfsr_q           <= SEED;
            alu_a_q          <= 32'd0;
            alu_b_q          <= 32'd0;
            alu_f_q          <= 3'd0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= 16'd0;
            first_fail_idx_q <= 16'hFFFF;
        end else begin
            state_q          <= state_d;
            vec_idx_q        <= vec_idx_d;
            op_cnt_q         <= op_cnt_d;
            lfsr_q           <= lfsr_d;
            alu_a_q          <= alu_a_d;
            alu_b_q          <= alu_b_d;
            alu_f_q          <= alu_f_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            err_count_q      <= err_count_d;
            first_fail_idx_q <= first_fail_idx_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_fail_idx = first_fail_idx_q;
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_f          = alu_f_q;

endmodule
